rx8_bcd_parser: RTL and testbench
=================================

// Module: rx8_bcd_parser
// PURPOSE
//   Receive-side counterpart of the 8-bit BCD/ASCII transmitter on the shared UART byte bus.
//   Consumes bytes strobed by the UART receiver and rebuilds 8-bit values from them:
//   - hex mode: two ASCII hex characters, high nibble first, form one byte.
//   - ASCII mode: each character is passed through unchanged.
//   CR/LF line endings are reported separately. Sits between the UART RX core and the lab command logic.
// PARAMETERS
//   PAIR_TIMEOUT  50000  clk cycles allowed between the 1st and 2nd hex chars before the pair is aborted
// PORTS
//   clk             in   1  system clock (single clock domain)
//   rst             in   1  asynchronous reset, active-low
//   rx_en           in   1  high: block listens to the bus; low: strobes ignored, FSM forced to RX_IDLE
//   rx_BCD          in   1  1 = hex-pair mode, 0 = ASCII pass-through; sampled on each accepted strobe
//   bu_rx_data      in   8  byte from UART receiver; valid only when bu_rx_data_rdy = 1
//   bu_rx_data_rdy  in   1  1-cycle strobe, one per received byte
//   rx_byte         out  8  last decoded byte; holds its value between pulses
//   rx_byte_vld     out  1  1-cycle pulse, rx_byte updated this cycle
//   rx_eol          out  1  1-cycle pulse on end-of-line
//   rx_err          out  1  1-cycle pulse on bad char, broken pair or timeout
//   rx_busy         out  1  high while a high nibble is held (state RX_HI)
// BEHAVIOUR
//   Reset: rx_byte = 8'h00; rx_byte_vld, rx_eol, rx_err, rx_busy = 0; state RX_IDLE; timeout counter = 0.
//   Outputs: all registered. Latency is 1 clk: a strobe at edge N produces its pulse or rx_byte update at edge N+1.
//   Strobes: at most one accepted per cycle; no backpressure; strobes arriving while rx_en = 0 are dropped.
//   Hex decode:
//     '0'-'9' (8'h30-39) -> 0-9
//     'A'-'F' (8'h41-46) and 'a'-'f' (8'h61-66) -> A-F
//     any other byte is non-hex.
//   States:
//     RX_IDLE:
//       - CR (8'h0D): pulse rx_eol; go to RX_CR.
//       - LF (8'h0A): pulse rx_eol; stay in RX_IDLE.
//       - rx_BCD = 0: rx_byte <= data; pulse rx_byte_vld.
//       - rx_BCD = 1, hex char: hold nibble as hi; clear counter; go to RX_HI.
//       - rx_BCD = 1, non-hex char: pulse rx_err; stay in RX_IDLE.
//     RX_HI (rx_busy = 1): counter increments every cycle without a strobe.
//       - hex char (rx_BCD ignored): rx_byte <= {hi, lo}; pulse rx_byte_vld; go to RX_IDLE.
//       - CR or LF: pulse rx_err and rx_eol together; nibble dropped; go to RX_CR on CR, RX_IDLE on LF.
//       - other char: pulse rx_err; go to RX_IDLE.
//       - counter reaches PAIR_TIMEOUT-1 with no strobe: pulse rx_err; go to RX_IDLE.
//     RX_CR:
//       - LF: swallowed, no pulse (CR+LF gives exactly one rx_eol); go to RX_IDLE.
//       - any other byte: handled exactly as in RX_IDLE in the same cycle.
//   Simultaneous events: a strobe in the timeout cycle wins; the pair completes normally.
//   rx_en falling: next edge clears state to RX_IDLE, drops any held nibble, no rx_err.
//   Async reset mid-pair: everything returns to reset values immediately; no pulse is emitted.
//   Counter width: $clog2(PAIR_TIMEOUT)+1; saturates, never wraps.
// TESTING
//   1 rx_BCD=1, strobes '3','F' -> rx_byte=8'h3F, one rx_byte_vld pulse 1 clk after the 'F' strobe.
//   2 rx_BCD=1, strobes 'a','0',CR,LF -> rx_byte=8'hA0, vld pulse, then exactly one rx_eol, no rx_err.
//   3 rx_BCD=1, strobes '7','G' -> rx_err pulse; rx_byte stays at previous value; state RX_IDLE.
//   4 PAIR_TIMEOUT=8, strobe '5' then idle 10 clks -> rx_err after 8 clks, rx_busy falls;
//     a following '1','2' yields 8'h12.
//   5 rx_BCD=0, strobes 'H',CR,'i' -> vld with 8'h48, rx_eol, vld with 8'h69;
//     a strobe with rx_en=0 -> no output.
//   6 Assert rst (low) while in RX_HI after '9' -> all outputs 0 at once;
//     after release, strobe '1' alone gives no vld.

Source files
------------

// File: rtl/rx8_bcd_parser.sv
// Receive-side byte parser for the UART byte bus: rebuilds bytes from ASCII hex pairs
// or passes ASCII through, and reports CR/LF line endings and malformed input.
module rx8_bcd_parser #(
  parameter int PAIR_TIMEOUT = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_en,
  input  logic       rx_BCD,
  input  logic [7:0] bu_rx_data,
  input  logic       bu_rx_data_rdy,
  output logic [7:0] rx_byte,
  output logic       rx_byte_vld,
  output logic       rx_eol,
  output logic       rx_err,
  output logic       rx_busy
);

  localparam int CW = $clog2(PAIR_TIMEOUT) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(PAIR_TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;
  localparam logic [7:0] CHAR_CR = 8'h0D;
  localparam logic [7:0] CHAR_LF = 8'h0A;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_HI,
    RX_CR
  } rx_state_t;

  rx_state_t     state, state_nxt;
  logic [3:0]    hi, hi_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [7:0]    byte_nxt;
  logic          vld_nxt, eol_nxt, err_nxt;
  logic          is_hex;
  logic [3:0]    nib;

  // {valid, nibble}; letters have low bits 1..6, so adding 9 maps them onto A..F
  function automatic logic [4:0] hex_decode(input logic [7:0] d);
    logic [4:0] r;
    r = 5'b0;
    if (d >= 8'h30 && d <= 8'h39)
      r = {1'b1, d[3:0]};
    else if ((d >= 8'h41 && d <= 8'h46) || (d >= 8'h61 && d <= 8'h66))
      r = {1'b1, d[3:0] + 4'd9};
    return r;
  endfunction

  assign {is_hex, nib} = hex_decode(bu_rx_data);

  always_comb begin
    state_nxt = state;
    hi_nxt    = hi;
    cnt_nxt   = cnt;
    byte_nxt  = rx_byte;
    vld_nxt   = 1'b0;
    eol_nxt   = 1'b0;
    err_nxt   = 1'b0;
    if (!rx_en) begin
      state_nxt = RX_IDLE;
    end else if (bu_rx_data_rdy) begin
      if (state == RX_HI) begin
        state_nxt = RX_IDLE;
        if (is_hex) begin
          byte_nxt = {hi, nib};
          vld_nxt  = 1'b1;
        end else if (bu_rx_data == CHAR_CR) begin
          err_nxt   = 1'b1;
          eol_nxt   = 1'b1;
          state_nxt = RX_CR;
        end else if (bu_rx_data == CHAR_LF) begin
          err_nxt = 1'b1;
          eol_nxt = 1'b1;
        end else begin
          err_nxt = 1'b1;
        end
      end else if (state == RX_CR && bu_rx_data == CHAR_LF) begin
        // LF completing a CR+LF pair was already reported with the CR
        state_nxt = RX_IDLE;
      end else begin
        state_nxt = RX_IDLE;
        if (bu_rx_data == CHAR_CR) begin
          eol_nxt   = 1'b1;
          state_nxt = RX_CR;
        end else if (bu_rx_data == CHAR_LF) begin
          eol_nxt = 1'b1;
        end else if (!rx_BCD) begin
          byte_nxt = bu_rx_data;
          vld_nxt  = 1'b1;
        end else if (is_hex) begin
          hi_nxt    = nib;
          cnt_nxt   = '0;
          state_nxt = RX_HI;
        end else begin
          err_nxt = 1'b1;
        end
      end
    end else if (state == RX_HI) begin
      if (cnt == CNT_LAST) begin
        err_nxt   = 1'b1;
        state_nxt = RX_IDLE;
      end else if (cnt != CNT_MAX) begin
        cnt_nxt = cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= RX_IDLE;
      hi          <= 4'h0;
      cnt         <= '0;
      rx_byte     <= 8'h00;
      rx_byte_vld <= 1'b0;
      rx_eol      <= 1'b0;
      rx_err      <= 1'b0;
      rx_busy     <= 1'b0;
    end else begin
      state       <= state_nxt;
      hi          <= hi_nxt;
      cnt         <= cnt_nxt;
      rx_byte     <= byte_nxt;
      rx_byte_vld <= vld_nxt;
      rx_eol      <= eol_nxt;
      rx_err      <= err_nxt;
      rx_busy     <= (state_nxt == RX_HI);
    end
  end

endmodule

// File: tb/tb_rx8_bcd_parser.sv
// Bench for rx8_bcd_parser: a cycle-level behavioural model checked on every falling edge,
// plus directed sequences with literal expectations, then randomized traffic.
module tb_rx8_bcd_parser;

  localparam int PT = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx_en = 1'b0;
  logic       rx_BCD = 1'b0;
  logic [7:0] bu_rx_data = 8'h00;
  logic       bu_rx_data_rdy = 1'b0;
  logic [7:0] rx_byte;
  logic       rx_byte_vld, rx_eol, rx_err, rx_busy;

  int n_chk = 0;
  int n_pass = 0;

  rx8_bcd_parser #(.PAIR_TIMEOUT(PT)) dut (
    .clk(clk), .rst(rst), .rx_en(rx_en), .rx_BCD(rx_BCD),
    .bu_rx_data(bu_rx_data), .bu_rx_data_rdy(bu_rx_data_rdy),
    .rx_byte(rx_byte), .rx_byte_vld(rx_byte_vld), .rx_eol(rx_eol),
    .rx_err(rx_err), .rx_busy(rx_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
  endtask

  function automatic int hexval(input logic [7:0] d);
    if (d >= "0" && d <= "9") return int'(d) - 48;
    if (d >= "A" && d <= "F") return int'(d) - 55;
    if (d >= "a" && d <= "f") return int'(d) - 87;
    return -1;
  endfunction

  // Model: a held high nibble is remembered with the cycle it arrived; the pair
  // times out once PT strobe-free cycles have elapsed since then.
  logic [7:0] m_byte;
  logic       m_vld, m_eol, m_err, m_busy;
  bit         pending, after_cr;
  int         hi_val, t_hi, cyc, hv;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_byte = 8'h00; m_vld = 0; m_eol = 0; m_err = 0; m_busy = 0;
      pending = 0; after_cr = 0; cyc = 0; t_hi = 0; hi_val = 0;
    end else begin
      cyc++;
      m_vld = 0; m_eol = 0; m_err = 0;
      if (!rx_en) begin
        pending = 0; after_cr = 0;
      end else if (bu_rx_data_rdy) begin
        hv = hexval(bu_rx_data);
        if (pending) begin
          pending = 0; after_cr = 0;
          if (hv >= 0) begin
            m_byte = 8'(hi_val * 16 + hv); m_vld = 1;
          end else if (bu_rx_data == 8'h0D) begin
            m_err = 1; m_eol = 1; after_cr = 1;
          end else if (bu_rx_data == 8'h0A) begin
            m_err = 1; m_eol = 1;
          end else m_err = 1;
        end else if (after_cr && bu_rx_data == 8'h0A) begin
          after_cr = 0;
        end else begin
          after_cr = 0;
          if (bu_rx_data == 8'h0D) begin
            m_eol = 1; after_cr = 1;
          end else if (bu_rx_data == 8'h0A) m_eol = 1;
          else if (!rx_BCD) begin
            m_byte = bu_rx_data; m_vld = 1;
          end else if (hv >= 0) begin
            pending = 1; hi_val = hv; t_hi = cyc;
          end else m_err = 1;
        end
      end else if (pending && (cyc - t_hi) >= PT) begin
        m_err = 1; pending = 0;
      end
      m_busy = pending;
    end
  end

  always @(negedge clk) begin
    check("byte", rx_byte, m_byte);
    check("vld", 8'(rx_byte_vld), 8'(m_vld));
    check("eol", 8'(rx_eol), 8'(m_eol));
    check("err", 8'(rx_err), 8'(m_err));
    check("busy", 8'(rx_busy), 8'(m_busy));
  end

  task automatic strobe(input logic [7:0] d);
    bu_rx_data = d;
    bu_rx_data_rdy = 1'b1;
    @(posedge clk);
    #1;
    bu_rx_data_rdy = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  string hx = "0123456789abcdefABCDEF";
  int    err_at;

  initial begin
    #22;
    check("rst_byte", rx_byte, 8'h00);
    check("rst_busy", 8'(rx_busy), 8'h00);
    rst = 1'b1;
    rx_en = 1'b1;
    idle(2);

    // pair '3','F'
    rx_BCD = 1'b1;
    strobe("3");
    check("t1_busy", 8'(rx_busy), 8'h01);
    check("t1_vld_early", 8'(rx_byte_vld), 8'h00);
    strobe("F");
    check("t1_byte", rx_byte, 8'h3F);
    check("t1_vld", 8'(rx_byte_vld), 8'h01);
    idle(1);
    check("t1_vld_once", 8'(rx_byte_vld), 8'h00);

    // 'a','0',CR,LF
    strobe("a");
    strobe("0");
    check("t2_byte", rx_byte, 8'hA0);
    strobe(8'h0D);
    check("t2_eol_cr", 8'(rx_eol), 8'h01);
    check("t2_err_cr", 8'(rx_err), 8'h00);
    strobe(8'h0A);
    check("t2_eol_lf", 8'(rx_eol), 8'h00);
    check("t2_err_lf", 8'(rx_err), 8'h00);

    // broken pair '7','G'
    strobe("7");
    strobe("G");
    check("t3_err", 8'(rx_err), 8'h01);
    check("t3_byte", rx_byte, 8'hA0);
    check("t3_busy", 8'(rx_busy), 8'h00);

    // timeout after '5'
    strobe("5");
    err_at = 0;
    for (int i = 1; i <= 10; i++) begin
      idle(1);
      if (rx_err && err_at == 0) err_at = i;
    end
    check("t4_err_at", 8'(err_at), 8'd8);
    check("t4_busy", 8'(rx_busy), 8'h00);
    strobe("1");
    strobe("2");
    check("t4_byte", rx_byte, 8'h12);

    // ASCII pass-through and rx_en gating
    rx_BCD = 1'b0;
    strobe("H");
    check("t5_byte_h", rx_byte, 8'h48);
    strobe(8'h0D);
    check("t5_eol", 8'(rx_eol), 8'h01);
    strobe("i");
    check("t5_byte_i", rx_byte, 8'h69);
    check("t5_vld_i", 8'(rx_byte_vld), 8'h01);
    rx_en = 1'b0;
    strobe("Z");
    check("t5_dis_vld", 8'(rx_byte_vld), 8'h00);
    check("t5_dis_byte", rx_byte, 8'h69);
    rx_en = 1'b1;

    // async reset mid-pair
    rx_BCD = 1'b1;
    strobe("9");
    check("t6_busy", 8'(rx_busy), 8'h01);
    #2 rst = 1'b0;
    #1;
    check("t6_rst_byte", rx_byte, 8'h00);
    check("t6_rst_busy", 8'(rx_busy), 8'h00);
    #2 rst = 1'b1;
    idle(1);
    strobe("1");
    check("t6_no_vld", 8'(rx_byte_vld), 8'h00);
    check("t6_err", 8'(rx_err), 8'h00);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      int sel;
      rx_en = ($urandom_range(0, 40) != 0);
      rx_BCD = ($urandom_range(0, 3) != 0);
      bu_rx_data_rdy = ($urandom_range(0, 1) == 1);
      sel = $urandom_range(0, 9);
      if (sel == 4) bu_rx_data = 8'h0D;
      else if (sel == 5) bu_rx_data = 8'h0A;
      else if (sel == 6) bu_rx_data = 8'($urandom);
      else bu_rx_data = hx[$urandom_range(0, 21)];
      @(posedge clk);
      #1;
      if ($urandom_range(0, 60) == 0) begin
        bu_rx_data_rdy = 1'b0;
        idle($urandom_range(5, 12));
      end
    end
    bu_rx_data_rdy = 1'b0;
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
